// File: rtl/dds_pkg.sv
// dds_pkg: shared constants, frame FSM encoding and the command-frame byte mux
// for the host-side DDS programming link.
package dds_pkg;
   localparam logic [7:0] HDR_BASE             = 8'hF0;
   localparam int         BYTES_PER_FRAME      = 3;
   localparam int         DEFAULT_CLKS_PER_BIT = 868;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

   // Header, then tuning word MSB first.
   function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic sel,
                                             input logic [15:0] word);
      return idx == 2'd0 ? (HDR_BASE | {7'd0, sel}) : idx == 2'd1 ? word[15:8] : word[7:0];
   endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser, LSB first. A byte offered on the last cycle
// of the stop bit is taken immediately so consecutive bytes leave no idle gap.
module uart_tx_byte
   import dds_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       ready,
   output logic       bit_done,
   output logic       tx
);
   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

   logic          active_q, active_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [3:0]    bit_q, bit_d;
   logic [8:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          last, load;

   assign bit_done = active_q && baud_q == BAUD_MAX;
   assign last     = bit_done && bit_q == 4'd9;
   assign ready    = !active_q || last;
   assign load     = valid && ready;
   assign tx       = tx_q;

   always_comb begin
      active_d = active_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      if (load) begin
         active_d = 1'b1;
         baud_d   = '0;
         bit_d    = '0;
         shift_d  = {1'b1, data};
         tx_d     = 1'b0;
      end else if (last) begin
         active_d = 1'b0;
         baud_d   = '0;
         bit_d    = '0;
         tx_d     = 1'b1;
      end else if (bit_done) begin
         baud_d  = '0;
         bit_d   = bit_q + 4'd1;
         tx_d    = shift_q[0];
         shift_d = {1'b1, shift_q[8:1]};
      end else if (active_q) begin
         baud_d = baud_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q <= 1'b0;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '1;
         tx_q     <= 1'b1;
      end else begin
         active_q <= active_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end
endmodule

// File: rtl/dds_prog_tx.sv
// dds_prog_tx: sends the 3-byte DDS programming frame (header, word MSB, word LSB)
// over UART; the frame FSM tracks the serialiser bit by bit.
module dds_prog_tx
   import dds_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int WORD_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              freq_sel,
   input  logic [WORD_W-1:0] freq_word,
   output logic              tx,
   output logic              busy,
   output logic              done
);
   state_t            state_q, state_d;
   logic [1:0]        byte_q, byte_d;
   logic [2:0]        bit_q, bit_d;
   logic              sel_q, sel_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              accept, last_byte, byte_valid, byte_ready, bit_done;
   logic [7:0]        byte_data;

   assign accept     = state_q == IDLE && start && !busy_q && byte_ready;
   assign last_byte  = byte_q == 2'(BYTES_PER_FRAME - 1);
   assign byte_valid = accept || (state_q == STOP && bit_done && !last_byte);
   // The header comes straight from the inputs so it can be loaded on the accepting edge.
   assign byte_data  = accept ? frame_byte(2'd0, freq_sel, freq_word)
                              : frame_byte(byte_q + 2'd1, sel_q, word_q);
   assign busy       = busy_q;
   assign done       = done_q;

   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
      .clk      (clk),
      .rst      (rst),
      .valid    (byte_valid),
      .data     (byte_data),
      .ready    (byte_ready),
      .bit_done (bit_done),
      .tx       (tx)
   );

   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      bit_d   = bit_q;
      sel_d   = sel_q;
      word_d  = word_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: if (accept) begin
            state_d = START;
            byte_d  = '0;
            sel_d   = freq_sel;
            word_d  = freq_word;
            busy_d  = 1'b1;
         end
         START: if (bit_done) begin
            state_d = DATA;
            bit_d   = '0;
         end
         DATA: if (bit_done) begin
            bit_d   = bit_q + 3'd1;
            state_d = bit_q == 3'd7 ? STOP : DATA;
         end
         STOP: if (bit_done) begin
            state_d = last_byte ? DONE : START;
            byte_d  = last_byte ? byte_q : byte_q + 2'd1;
            busy_d  = !last_byte;
            done_d  = last_byte;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         byte_q  <= '0;
         bit_q   <= '0;
         sel_q   <= 1'b0;
         word_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         bit_q   <= bit_d;
         sel_q   <= sel_d;
         word_q  <= word_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_dds_prog_tx.sv
// tb_dds_prog_tx: two instances (4 and 868 clocks per bit) checked every cycle
// against a frame-timeline model, plus a mid-bit UART decoder and literal checks.
module tb_dds_prog_tx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_v[2];
   logic        sel_v[2];
   logic [15:0] word_v[2];
   logic        tx_v[2];
   logic        busy_v[2];
   logic        done_v[2];

   always #5 clk = ~clk;

   dds_prog_tx #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst(rst), .start(start_v[0]), .freq_sel(sel_v[0]), .freq_word(word_v[0]),
      .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   dds_prog_tx #(.CLKS_PER_BIT(868)) dut868 (
      .clk(clk), .rst(rst), .start(start_v[1]), .freq_sel(sel_v[1]), .freq_word(word_v[1]),
      .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

   function automatic int cpb(int i);
      return i == 0 ? 4 : 868;
   endfunction

   // Model: t = clock periods since the accepting edge (1 = first start-bit cycle), -1 = idle.
   int         t[2] = '{-1, -1};
   logic [7:0] mbyte[2][3];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         t[0] <= -1;
         t[1] <= -1;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (t[i] < 0) begin
               if (start_v[i]) begin
                  t[i]        <= 1;
                  mbyte[i][0] <= 8'hF0 | {7'd0, sel_v[i]};
                  mbyte[i][1] <= word_v[i][15:8];
                  mbyte[i][2] <= word_v[i][7:0];
               end
            end else begin
               t[i] <= (t[i] == 1 + 30 * cpb(i)) ? -1 : t[i] + 1;
            end
         end
      end
   end

   function automatic logic exp_tx(int i);
      int k;
      if (t[i] < 1 || t[i] > 30 * cpb(i)) return 1'b1;
      k = (t[i] - 1) / cpb(i);
      if (k % 10 == 0) return 1'b0;
      if (k % 10 == 9) return 1'b1;
      return mbyte[i][k / 10][k % 10 - 1];
   endfunction

   int m_vec = 0, m_bad = 0;
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic eb, ed;
         eb = t[i] >= 1 && t[i] <= 30 * cpb(i);
         ed = t[i] == 1 + 30 * cpb(i);
         m_vec <= m_vec + 1;
         if (tx_v[i] !== exp_tx(i) || busy_v[i] !== eb || done_v[i] !== ed) begin
            m_bad <= m_bad + 1;
            if (m_bad < 20)
               $display("FAIL timeline dut%0d t=%0d: tx/busy/done got %b%b%b want %b%b%b",
                        i, t[i], tx_v[i], busy_v[i], done_v[i], exp_tx(i), eb, ed);
         end
      end
   end

   // Mid-bit UART decoder.
   int         p[2] = '{-1, -1};
   int         ferr[2] = '{0, 0};
   logic [7:0] sh[2];
   logic [7:0] q0[$], q1[$];
   int         dcnt[2] = '{0, 0};

   always @(negedge clk or negedge rst) begin
      if (!rst) begin
         p[0] <= -1;
         p[1] <= -1;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (done_v[i]) dcnt[i] <= dcnt[i] + 1;
            if (p[i] < 0) begin
               if (!tx_v[i]) p[i] <= 0;
            end else if (p[i] == 9 * cpb(i) + cpb(i) / 2) begin
               if (i == 0) q0.push_back(sh[0]);
               else q1.push_back(sh[1]);
               if (!tx_v[i]) ferr[i] <= ferr[i] + 1;
               p[i] <= -1;
            end else begin
               if (p[i] % cpb(i) == cpb(i) / 2) begin
                  if (p[i] / cpb(i) == 0) begin
                     if (tx_v[i]) ferr[i] <= ferr[i] + 1;
                  end else sh[i][p[i] / cpb(i) - 1] <= tx_v[i];
               end
               p[i] <= p[i] + 1;
            end
         end
      end
   end

   int l_vec = 0, l_bad = 0;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic lit(input string name, input int act, input int exp);
      l_vec++;
      if (act !== exp) begin
         l_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic send(input int i, input logic s, input logic [15:0] w);
      start_v[i] = 1'b1;
      sel_v[i]   = s;
      word_v[i]  = w;
      tick();
      start_v[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, output int n);
      n = 1;
      while (!done_v[i] && n < 40 * cpb(i)) begin
         tick();
         n++;
      end
   endtask

   task automatic check_byte(input int i, input int idx, input logic [7:0] exp);
      int sz;
      sz = i == 0 ? q0.size() : q1.size();
      if (idx < sz) lit($sformatf("rx byte dut%0d #%0d", i, idx), i == 0 ? q0[idx] : q1[idx], exp);
      else lit($sformatf("rx byte dut%0d #%0d missing", i, idx), -1, exp);
   endtask

   initial begin
      int n, base, d0;
      int vectors, miscompares;
      for (int i = 0; i < 2; i++) begin
         start_v[i] = 1'b0;
         sel_v[i]   = 1'b0;
         word_v[i]  = 16'h0;
      end
      #1 rst = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      repeat (20) tick();
      lit("reset tx", tx_v[0], 1);
      lit("reset busy", busy_v[0], 0);
      lit("reset done", done_v[0], 0);

      base = q0.size();
      send(0, 1'b1, 16'h1234);
      lit("tx low at cycle 1", tx_v[0], 0);
      lit("busy at cycle 1", busy_v[0], 1);
      wait_done(0, n);
      lit("done cycle", n, 121);
      lit("busy low with done", busy_v[0], 0);
      tick();
      lit("done one cycle", done_v[0], 0);
      check_byte(0, base, 8'hF1);
      check_byte(0, base + 1, 8'h12);
      check_byte(0, base + 2, 8'h34);
      repeat (3) tick();

      base = q0.size();
      send(0, 1'b1, 16'h1234);
      sel_v[0]  = 1'b0;
      word_v[0] = 16'hFFFF;
      wait_done(0, n);
      lit("latched done cycle", n, 121);
      check_byte(0, base, 8'hF1);
      check_byte(0, base + 1, 8'h12);
      check_byte(0, base + 2, 8'h34);
      repeat (3) tick();

      base = q0.size();
      d0   = dcnt[0];
      send(0, 1'b0, 16'hA55A);
      repeat (9) tick();
      send(0, 1'b1, 16'h0F0F);
      repeat (49) tick();
      send(0, 1'b1, 16'h7777);
      repeat (150) tick();
      lit("one done while busy", dcnt[0] - d0, 1);
      lit("one frame while busy", q0.size() - base, 3);
      check_byte(0, base, 8'hF0);
      check_byte(0, base + 1, 8'hA5);
      check_byte(0, base + 2, 8'h5A);

      send(0, 1'b1, 16'hBEEF);
      repeat (49) tick();
      #2 rst = 1'b0;
      #1;
      lit("async reset tx", tx_v[0], 1);
      lit("async reset busy", busy_v[0], 0);
      lit("async reset done", done_v[0], 0);
      repeat (3) tick();
      rst = 1'b1;
      repeat (2) tick();
      base = q0.size();
      send(0, 1'b0, 16'h0001);
      wait_done(0, n);
      lit("post-reset done cycle", n, 121);
      check_byte(0, base, 8'hF0);
      check_byte(0, base + 1, 8'h00);
      check_byte(0, base + 2, 8'h01);
      repeat (3) tick();

      base = q1.size();
      send(1, 1'b0, 16'hABCD);
      wait_done(1, n);
      lit("868 frame A done cycle", n, 26041);
      start_v[1] = 1'b1;
      sel_v[1]   = 1'b1;
      word_v[1]  = 16'h0000;
      tick();
      lit("start in DONE ignored", busy_v[1], 0);
      lit("idle tx after done", tx_v[1], 1);
      tick();
      start_v[1] = 1'b0;
      lit("next start busy", busy_v[1], 1);
      lit("next start tx", tx_v[1], 0);
      wait_done(1, n);
      lit("868 frame B done cycle", n, 26041);
      check_byte(1, base, 8'hF0);
      check_byte(1, base + 1, 8'hAB);
      check_byte(1, base + 2, 8'hCD);
      check_byte(1, base + 3, 8'hF1);
      check_byte(1, base + 4, 8'h00);
      check_byte(1, base + 5, 8'h00);
      lit("framing errors", ferr[0] + ferr[1], 0);
      repeat (3) tick();

      vectors     = m_vec + l_vec;
      miscompares = m_bad + l_bad;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/dds_prog_tx.md
Name: dds_prog_tx

Overview:
UART transmitter that programs a DDS frequency register over the serial `rx` line. It is the host-side counterpart of the DDS's UART receiver. It takes a 16-bit tuning word plus a register select, then serialises a fixed 3-byte command frame, 8N1, LSB first. It is used in test harnesses and in multi-board setups where one FPGA drives the DDS of another.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
WORD_W, 16, tuning word width; fixed at 16 (frame carries exactly 2 data bytes).

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low (block held in reset while rst==0)
start  input  1  one-cycle request to send a frame; honoured only when idle
freq_sel  input  1  0 = program freq0 register, 1 = program freq1 register
freq_word  input  16  tuning word (phase increment) to program
tx  output  1  UART serial line to DDS rx; idle high
busy  output  1  high from cycle after accepted start until frame complete
done  output  1  one-cycle pulse when final stop bit has completed

Behaviour:
- Reset (async assert, rst==0): tx=1, busy=0, done=0, FSM=IDLE, all counters 0. Takes effect immediately, including mid-frame; no partial byte resumes after release.
- Frame, in order:
  - byte0 header = 8'hF0 | {7'b0, freq_sel} (0xF0 or 0xF1)
  - byte1 = freq_word[15:8]
  - byte2 = freq_word[7:0]
- Each byte is 10 bits: start (0), d0..d7 LSB first, stop (1). Bytes are back-to-back with no idle gap; total 30 bit periods.
- Each bit is held exactly CLKS_PER_BIT cycles, timed by a baud counter (0..CLKS_PER_BIT-1). The counter restarts at each bit boundary.
- Handshake:
  - Accept: start==1 while FSM==IDLE and busy==0. freq_sel and freq_word are latched on the accepting edge; later input changes do not affect the frame.
  - Timing: with the accepting edge as cycle 0, tx=0 and busy=1 from cycle 1.
  - Ignore: start while busy is dropped silently; it is not queued.
- FSM states and transitions:
  - IDLE -> START on accept
  - START -> DATA after CLKS_PER_BIT
  - DATA -> STOP after 8 bits
  - STOP -> START (byte index <2, index++)
  - STOP -> DONE (byte index ==2)
  - DONE -> IDLE after 1 cycle
- Completion: the last stop bit occupies cycles 1+29*CLKS_PER_BIT .. 30*CLKS_PER_BIT. On cycle 1+30*CLKS_PER_BIT, done=1 and busy=0, both in the DONE state; tx stays 1.
- Back-to-back: start asserted in the DONE cycle is ignored. The earliest acceptable start is the cycle after done, giving at least one idle bit-less cycle between frames.
- Register outputs: tx, busy and done are driven straight from flops (no combinational path from inputs). The tx line must not glitch.
- Width rules:
  - Baud counter width = $clog2(CLKS_PER_BIT).
  - Bit index 0..7 (3 bits); byte index 0..2 (2 bits).
  - Shift register 8 bits, loaded at entry to START from a byte mux selected by byte index.
- freq_word==0 is legal and is sent as-is. The receiving DDS interprets freq1==0 as OOK mode; this block adds no special handling.

Decomposition:
- Shared package dds_pkg:
  - HDR_BASE = 8'hF0
  - state enum {IDLE, START, DATA, STOP, DONE}
  - BYTES_PER_FRAME = 3
  - DEFAULT_CLKS_PER_BIT = 868
- Sub-module uart_tx_byte: byte serialiser with a byte-level handshake (load/valid in, ready/bit_done out), parameterised by CLKS_PER_BIT. The top-level dds_prog_tx keeps the frame FSM, byte mux and input latches.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release -> tx=1, busy=0, done=0 throughout and 20 cycles after release.
- Single frame (CLKS_PER_BIT=4, freq_sel=1, freq_word=16'h1234): start pulse at cycle 0.
  - Bench UART monitor sampling mid-bit decodes bytes F1, 12, 34.
  - tx falls at cycle 1; done pulses exactly at cycle 121; busy is high over cycles 1..120.
- Input latching: change freq_word to 16'hFFFF and freq_sel to 0 in the cycle after start -> monitor still decodes F1, 12, 34.
- Start while busy: pulse start at cycles 10 and 60 with different data -> exactly one frame is sent and one done pulse is seen.
- Mid-frame reset: drive rst=0 at cycle 50 of a frame -> tx=1 and busy=0 asynchronously (before next clk edge).
  - After release, a new start (freq_sel=0, freq_word=16'h0001) produces a clean F0, 00, 01 frame.
- Back-to-back: start in the DONE cycle is ignored; start one cycle later is accepted.
  - With CLKS_PER_BIT=868, two frames (F0,AB,CD / F1,00,00) decode correctly, each 30 bit periods.
